// File: rtl/multi_slot_packet_buffer.sv
// Multi-slot packet buffer: slots rotate fill -> process -> send -> free in strict order.
// Optional PB_REPEAT_EN: per-slot repeat count re-queues a drained packet for retransmission.
module multi_slot_packet_buffer #(
  parameter int NUM_SLOTS = 2,
  parameter int SLOT_AW   = 8,
  parameter int ROUTE_W   = 24
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [63:0]                   in_data,
  input  logic [ROUTE_W-1:0]            in_pkt_route,
  input  logic                          in_wr,
  input  logic                          in_req,
  output logic                          in_ack,
  output logic                          in_empty,
  output logic [63:0]                   out_data,
  output logic [ROUTE_W-1:0]            out_pkt_route,
  output logic [1:0]                    out_neighbor,
  output logic                          out_bypass,
  output logic                          out_wr,
  output logic                          out_bop,
  output logic                          out_eop,
  output logic                          out_req,
  input  logic                          out_ack,
  input  logic                          out_rdy,
  input  logic [SLOT_AW:0]              proc_addr,
  input  logic [31:0]                   proc_data_in,
  output logic [31:0]                   proc_data_out,
  input  logic                          proc_we,
  output logic                          proc_req,
  input  logic                          proc_done,
  input  logic                          proc_wr_pkt_len,
  input  logic [SLOT_AW:0]              proc_pkt_len,
  input  logic [7:0]                    proc_repeat,
  output logic                          ovf_err,
  output logic [$clog2(NUM_SLOTS):0]    slots_free
);
  localparam int PTR_W  = $clog2(NUM_SLOTS);
  localparam int LEN_W  = SLOT_AW + 1;
  localparam int RAM_AW = PTR_W + SLOT_AW;
  localparam logic [LEN_W-1:0] SLOT_WORDS = LEN_W'(1) << SLOT_AW;
  localparam logic [LEN_W-1:0] LEN_ONE    = LEN_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);

  typedef enum logic [2:0] {S_FREE, S_RECV, S_PROC, S_READY, S_SEND, S_DRAIN} slot_state_e;

  slot_state_e        state_q [NUM_SLOTS];
  slot_state_e        state_d [NUM_SLOTS];
  logic [LEN_W-1:0]   len_q   [NUM_SLOTS];
  logic [LEN_W-1:0]   len_d   [NUM_SLOTS];
  logic [ROUTE_W-1:0] route_q [NUM_SLOTS];
  logic [ROUTE_W-1:0] route_d [NUM_SLOTS];
  logic [PTR_W-1:0]   fill_ptr_q, fill_ptr_d, proc_ptr_q, proc_ptr_d, send_ptr_q, send_ptr_d;
  logic [LEN_W-1:0]   rd_idx_q, rd_idx_d;
  logic               out_wr_d, out_bop_d, out_eop_d, ovf_err_d;
  logic [PTR_W:0]     slots_free_d;
`ifdef PB_REPEAT_EN
  logic [7:0]         rep_q [NUM_SLOTS];
  logic [7:0]         rep_d [NUM_SLOTS];
`else
  logic               unused_repeat;
  assign unused_repeat = ^proc_repeat;
`endif

  slot_state_e        fill_st, send_st;
  logic [LEN_W-1:0]   send_len;
  logic               proc_active, rx_we, rd_en, route_hold;
  logic [ROUTE_W-1:0] route_cur;
  logic [RAM_AW-1:0]  pa_addr, pb_addr;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    state_d    = state_q;
    len_d      = len_q;
    route_d    = route_q;
`ifdef PB_REPEAT_EN
    rep_d      = rep_q;
`endif
    fill_ptr_d = fill_ptr_q;
    proc_ptr_d = proc_ptr_q;
    send_ptr_d = send_ptr_q;
    rd_idx_d   = rd_idx_q;
    in_ack     = 1'b0;
    rx_we      = 1'b0;
    ovf_err_d  = 1'b0;
    out_req    = 1'b0;
    rd_en      = 1'b0;
    route_hold = 1'b0;

    // Receive side: owns slot[fill_ptr] while it is FREE or RECV.
    fill_st = state_q[fill_ptr_q];
    in_ack  = (fill_st == S_RECV) || (fill_st == S_FREE && in_req);
    if (in_ack) begin
      if (fill_st == S_FREE) state_d[fill_ptr_q] = S_RECV;
      if (in_wr) begin
        if (len_q[fill_ptr_q] == SLOT_WORDS) begin
          ovf_err_d = 1'b1;
        end else begin
          rx_we = 1'b1;
          len_d[fill_ptr_q] = len_q[fill_ptr_q] + LEN_ONE;
          if (len_q[fill_ptr_q] == '0) route_d[fill_ptr_q] = in_pkt_route;
        end
      end
      if (fill_st == S_RECV && !in_req) begin
        state_d[fill_ptr_q] = S_PROC;
        fill_ptr_d          = fill_ptr_q + 1'b1;
      end
    end
    in_empty = (fill_st == S_FREE) && !in_ack;

    // Processor side: the override is written before proc_done hands the slot on.
    proc_active = (state_q[proc_ptr_q] == S_PROC);
    proc_req    = proc_active && !proc_done;
    if (proc_active) begin
      if (proc_wr_pkt_len) len_d[proc_ptr_q] = proc_pkt_len;
      if (proc_done) begin
        state_d[proc_ptr_q] = S_READY;
        proc_ptr_d          = proc_ptr_q + 1'b1;
`ifdef PB_REPEAT_EN
        rep_d[proc_ptr_q]   = proc_repeat;
`endif
      end
    end

    // Send side: a receive write on port B steals the read slot for one cycle.
    send_st  = state_q[send_ptr_q];
    send_len = len_q[send_ptr_q];
    case (send_st)
      S_READY: begin
        if (send_len == '0) begin
          state_d[send_ptr_q] = S_FREE;
          send_ptr_d          = send_ptr_q + 1'b1;
        end else begin
          out_req = 1'b1;
          if (out_ack) begin
            state_d[send_ptr_q] = S_SEND;
            route_hold          = 1'b1;
            rd_idx_d            = '0;
          end
        end
      end
      S_SEND: begin
        out_req    = 1'b1;
        route_hold = 1'b1;
        if (out_rdy && !rx_we && rd_idx_q != send_len) begin
          rd_en    = 1'b1;
          rd_idx_d = rd_idx_q + LEN_ONE;
        end
        if (out_wr && out_eop) state_d[send_ptr_q] = S_DRAIN;
      end
      S_DRAIN: begin
        route_hold = 1'b1;
        if (!out_ack) begin
`ifdef PB_REPEAT_EN
          if (rep_q[send_ptr_q] != 8'd0) begin
            rep_d[send_ptr_q]   = rep_q[send_ptr_q] - 8'd1;
            state_d[send_ptr_q] = S_READY;
          end else begin
            state_d[send_ptr_q] = S_FREE;
            len_d[send_ptr_q]   = '0;
            send_ptr_d          = send_ptr_q + 1'b1;
          end
`else
          state_d[send_ptr_q] = S_FREE;
          len_d[send_ptr_q]   = '0;
          send_ptr_d          = send_ptr_q + 1'b1;
`endif
        end
      end
      default: ;
    endcase

    out_wr_d  = rd_en;
    out_bop_d = rd_en && (rd_idx_q == '0);
    out_eop_d = rd_en && (rd_idx_q == send_len - LEN_ONE);

    route_cur     = route_q[send_ptr_q];
    out_pkt_route = route_hold ? (route_cur >> 3) : '0;
    out_neighbor  = route_hold ? route_cur[1:0] : 2'b00;
    out_bypass    = route_hold ? route_cur[5] : 1'b0;

    slots_free_d = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (state_d[i] == S_FREE) slots_free_d = slots_free_d + CNT_ONE;

    pa_addr = {proc_ptr_q, proc_addr[SLOT_AW:1]};
    pb_addr = rx_we ? {fill_ptr_q, len_q[fill_ptr_q][SLOT_AW-1:0]}
                    : {send_ptr_q, rd_idx_q[SLOT_AW-1:0]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        state_q[i] <= S_FREE;
        len_q[i]   <= '0;
        route_q[i] <= '0;
`ifdef PB_REPEAT_EN
        rep_q[i]   <= '0;
`endif
      end
      fill_ptr_q <= '0;
      proc_ptr_q <= '0;
      send_ptr_q <= '0;
      rd_idx_q   <= '0;
      out_wr     <= 1'b0;
      out_bop    <= 1'b0;
      out_eop    <= 1'b0;
      ovf_err    <= 1'b0;
      slots_free <= (PTR_W+1)'(NUM_SLOTS);
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      len_q      <= len_d;
      route_q    <= route_d;
`ifdef PB_REPEAT_EN
      rep_q      <= rep_d;
`endif
      fill_ptr_q <= fill_ptr_d;
      proc_ptr_q <= proc_ptr_d;
      send_ptr_q <= send_ptr_d;
      rd_idx_q   <= rd_idx_d;
      out_wr     <= out_wr_d;
      out_bop    <= out_bop_d;
      out_eop    <= out_eop_d;
      ovf_err    <= ovf_err_d;
      slots_free <= slots_free_d;
    end
  end

  // Packet RAM split in 32-bit halves so the processor port can write one half.
  logic [31:0] ram_hi [2**RAM_AW];
  logic [31:0] ram_lo [2**RAM_AW];

  // NOTE: the RAM array is deliberately not reset; only its read registers are.
  always_ff @(posedge clk) begin
    if (proc_we && proc_active) begin
      if (proc_addr[0]) ram_lo[pa_addr] <= proc_data_in;
      else              ram_hi[pa_addr] <= proc_data_in;
    end
    if (rx_we) begin
      ram_hi[pb_addr] <= in_data[63:32];
      ram_lo[pb_addr] <= in_data[31:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      proc_data_out <= '0;
      out_data      <= '0;
    end else begin
      proc_data_out <= proc_addr[0] ? ram_lo[pa_addr] : ram_hi[pa_addr];
      if (rd_en) out_data <= {ram_hi[pb_addr], ram_lo[pb_addr]};
    end
  end
endmodule
